// File: rtl/barcode_pkg.sv
// Shared widths, fixed start/stop patterns and FSM state encoding for the
// barcode frame serializer.
package barcode_pkg;

  localparam int unsigned SEG_W  = 11;
  localparam int unsigned STOP_W = 13;

  localparam logic [SEG_W-1:0]  START_PAT = 11'b11010011100;
  localparam logic [STOP_W-1:0] STOP_PAT  = 13'b1100011101011;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_QPRE,
    S_START,
    S_DATA,
    S_CHECK,
    S_STOP,
    S_QPOST
  } state_t;

endpackage

// File: rtl/barcode_symbol_rom.sv
// Combinational 16-entry symbol table: 4-bit value to 11-module bar pattern,
// leftmost (MSB) module transmitted first.
module barcode_symbol_rom
  import barcode_pkg::*;
(
  input  logic [3:0]       value,
  output logic [SEG_W-1:0] pattern_c
);

  always_comb begin
    pattern_c = '0;
    case (value)
      4'd0:  pattern_c = 11'b11011001100;
      4'd1:  pattern_c = 11'b11001101100;
      4'd2:  pattern_c = 11'b11001100110;
      4'd3:  pattern_c = 11'b10010011000;
      4'd4:  pattern_c = 11'b10010001100;
      4'd5:  pattern_c = 11'b10001001100;
      4'd6:  pattern_c = 11'b10011001000;
      4'd7:  pattern_c = 11'b10011000100;
      4'd8:  pattern_c = 11'b10001100100;
      4'd9:  pattern_c = 11'b11001001000;
      4'd10: pattern_c = 11'b11001000100;
      4'd11: pattern_c = 11'b11000100100;
      4'd12: pattern_c = 11'b10110011100;
      4'd13: pattern_c = 11'b10011011100;
      4'd14: pattern_c = 11'b10011001110;
      default: pattern_c = 11'b10111001100;
    endcase
  end

endmodule

// File: rtl/barcode_frame_serializer.sv
// Buffers 1..MAX_DIGITS digits, accumulates a weighted mod-16 check value and
// shifts the quiet/start/data/check/stop/quiet frame out on a single bar line.
module barcode_frame_serializer
  import barcode_pkg::*;
#(
  parameter int unsigned MAX_DIGITS  = 8,
  parameter int unsigned MODULE_CLKS = 1,
  parameter int unsigned QUIET       = 10,
  parameter int unsigned CHECK_EN    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] digit_data,
  input  logic       digit_valid,
  input  logic       digit_last,
  output logic       digit_ready,
  output logic       bar,
  output logic       bar_valid,
  output logic       sof,
  output logic       eof,
  output logic       overflow
);

  localparam int unsigned CNT_W      = $clog2(MAX_DIGITS + 1);
  localparam int unsigned IDX_W      = (MAX_DIGITS > 1) ? $clog2(MAX_DIGITS) : 1;
  localparam int unsigned MC_W       = (MODULE_CLKS > 1) ? $clog2(MODULE_CLKS) : 1;
  localparam int unsigned POS_MAX    = (QUIET > STOP_W) ? QUIET : STOP_W;
  localparam int unsigned POS_W      = $clog2(POS_MAX);
  localparam int unsigned QUIET_LAST = (QUIET > 0) ? QUIET - 1 : 0;
  localparam state_t      LAST_SEG   = (QUIET > 0) ? S_QPOST : S_STOP;

  state_t             state, state_n;
  logic [3:0]         digits [MAX_DIGITS];
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   sym_idx, sym_n;
  logic [3:0]         chk;
  logic [3:0]         weight;
  logic [MC_W-1:0]    mod_cnt, mod_n;
  logic [POS_W-1:0]   bit_idx, bit_n;
  logic               xfer, load_done;
  logic               bar_n, valid_n, sof_n, eof_n, ovf_n, ready_n;
  logic [3:0]         rom_value;
  logic [SEG_W-1:0]   rom_pat;
  logic [3:0]         seg_pos, stop_pos;

  // Index of the last module of each segment.
  function automatic logic [POS_W-1:0] seg_last(input state_t s);
    case (s)
      S_QPRE, S_QPOST: seg_last = POS_W'(QUIET_LAST);
      S_STOP:          seg_last = POS_W'(STOP_W - 1);
      default:         seg_last = POS_W'(SEG_W - 1);
    endcase
  endfunction

  assign xfer   = digit_valid && digit_ready;
  assign weight = 4'(count) + 4'd1;

  // Next state, module/bit/symbol counters, and next values of the registered outputs.
  always_comb begin
    state_n   = state;
    mod_n     = mod_cnt;
    bit_n     = bit_idx;
    sym_n     = sym_idx;
    load_done = xfer && (digit_last || (count == CNT_W'(MAX_DIGITS - 1)));

    unique case (state)
      S_IDLE: state_n = S_LOAD;
      S_LOAD: begin
        if (load_done) begin
          state_n = (QUIET > 0) ? S_QPRE : S_START;
          mod_n   = '0;
          bit_n   = '0;
          sym_n   = '0;
        end
      end
      default: begin
        if (mod_cnt != MC_W'(MODULE_CLKS - 1)) begin
          mod_n = mod_cnt + 1'b1;
        end else begin
          mod_n = '0;
          if (bit_idx != seg_last(state)) begin
            bit_n = bit_idx + 1'b1;
          end else begin
            bit_n = '0;
            case (state)
              S_QPRE:  state_n = S_START;
              S_START: begin
                state_n = S_DATA;
                sym_n   = '0;
              end
              S_DATA: begin
                if (sym_idx == count - 1'b1) state_n = (CHECK_EN != 0) ? S_CHECK : S_STOP;
                else                         sym_n   = sym_idx + 1'b1;
              end
              S_CHECK: state_n = S_STOP;
              S_STOP:  state_n = (QUIET > 0) ? S_QPOST : S_LOAD;
              default: state_n = S_LOAD;
            endcase
          end
        end
      end
    endcase

    valid_n = (state_n != S_IDLE) && (state_n != S_LOAD);
    ready_n = (state_n == S_LOAD);
    sof_n   = load_done;
    ovf_n   = load_done && !digit_last;
    eof_n   = (state_n == LAST_SEG) && (bit_n == seg_last(LAST_SEG)) &&
              (mod_n == MC_W'(MODULE_CLKS - 1));
  end

  assign rom_value = (state_n == S_CHECK) ? chk : digits[IDX_W'(sym_n)];

  barcode_symbol_rom u_rom (
    .value     (rom_value),
    .pattern_c (rom_pat)
  );

  // Bar level of the module about to be presented, leftmost pattern bit first.
  always_comb begin
    seg_pos  = 4'(SEG_W - 1) - 4'(bit_n);
    stop_pos = 4'(STOP_W - 1) - 4'(bit_n);
    bar_n    = 1'b0;
    case (state_n)
      S_START:         bar_n = START_PAT[seg_pos];
      S_DATA, S_CHECK: bar_n = rom_pat[seg_pos];
      S_STOP:          bar_n = STOP_PAT[stop_pos];
      default:         bar_n = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      mod_cnt     <= '0;
      bit_idx     <= '0;
      sym_idx     <= '0;
      count       <= '0;
      chk         <= '0;
      digit_ready <= 1'b0;
      bar         <= 1'b0;
      bar_valid   <= 1'b0;
      sof         <= 1'b0;
      eof         <= 1'b0;
      overflow    <= 1'b0;
      for (int i = 0; i < int'(MAX_DIGITS); i++) digits[i] <= '0;
    end else begin
      state       <= state_n;
      mod_cnt     <= mod_n;
      bit_idx     <= bit_n;
      sym_idx     <= sym_n;
      digit_ready <= ready_n;
      bar         <= bar_n;
      bar_valid   <= valid_n;
      sof         <= sof_n;
      eof         <= eof_n;
      overflow    <= ovf_n;
      // Payload and check restart on every return to LOAD so back-to-back frames are independent.
      if (xfer) begin
        digits[IDX_W'(count)] <= digit_data;
        count                 <= count + 1'b1;
        chk                   <= chk + weight * digit_data;
      end else if ((state != S_LOAD) && (state_n == S_LOAD)) begin
        count <= '0;
        chk   <= '0;
      end
    end
  end

endmodule
